// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: EX/M control bit indices,
// FSM state encoding and byte-enable helpers.
package mem_stage_pkg;

    localparam int CTL_MEM_READ   = 0;
    localparam int CTL_MEM_WRITE  = 1;
    localparam int CTL_BYTE       = 2;
    localparam int CTL_REG_WRITE  = 3;
    localparam int CTL_MEM_TO_REG = 4;
    localparam int CTL_BRANCH     = 5;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot byte enable for the lane addressed by the low address bits.
    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            2'd3:    be = 4'b1000;
            default: be = 4'b0001;
        endcase
        return be;
    endfunction

    // Store data as presented on the bus: byte stores replicate into every lane.
    function automatic logic [31:0] store_data(input logic [31:0] data, input logic is_byte);
        logic [31:0] wd;
        if (is_byte) begin
            wd = {4{data[7:0]}};
        end else begin
            wd = data;
        end
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_align.sv
// Load alignment: selects the addressed byte lane of the memory read data and
// sign-extends it for byte loads; word loads pass through unchanged.
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        is_byte,
    output logic [31:0] value
);

    logic [7:0] byte_s;

    // Byte lane selection by address offset.
    always_comb begin
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Sign extension for byte loads.
    always_comb begin
        if (is_byte) begin
            value = {{24{byte_s[7]}}, byte_s};
        end else begin
            value = rdata;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: decodes the EX/M bundle, runs valid/ack data-memory transactions
// with timeout, drives the pipeline stall and owns the M/WB register.
// Build option: define MISALIGN_TRAP_EN to trap unaligned word accesses (adds misalign_trap).
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       alu_output_in,
    input  logic [31:0]       next_pc_in,
    input  logic              take_branch_in,
    input  logic [31:0]       data_in,
    input  logic [5:0]        control_in,
    input  logic [4:0]        rgD_index_in,
    output logic              stall,
    output logic              pc_redirect,
    output logic [31:0]       pc_target,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_error,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rgD,
    output logic              wb_reg_write
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  cnt_r;
    logic [31:0] load_r;
    logic        failed_r;

    logic        mem_op_s;
    logic        is_write_s;
    logic        is_byte_s;
    logic        trap_s;
    logic        timeout_s;
    logic [ADDR_W-1:0] addr_s;
    logic [3:0]  be_s;
    logic [31:0] load_val_s;
    logic [31:0] alu_wb_s;

    // A request with both read and write set is a write.
    assign mem_op_s   = control_in[CTL_MEM_READ] | control_in[CTL_MEM_WRITE];
    assign is_write_s = control_in[CTL_MEM_WRITE];
    assign is_byte_s  = control_in[CTL_BYTE];
    assign timeout_s  = (state_r == REQ) & ~mem_ack & (cnt_r == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
    assign trap_s = mem_op_s & ~is_byte_s & (alu_output_in[1:0] != 2'b00);
`else
    assign trap_s = 1'b0;
`endif

    assign pc_redirect = control_in[CTL_BRANCH] & take_branch_in;
    assign pc_target   = alu_output_in;

    // Request address and byte-enable decode from the EX/M address.
    always_comb begin
        if (is_byte_s) begin
            addr_s = alu_output_in[ADDR_W-1:0];
            be_s   = byte_be(alu_output_in[1:0]);
        end else begin
            addr_s = {alu_output_in[ADDR_W-1:2], 2'b00};
            be_s   = BE_WORD;
        end
    end

    // Writeback value for non-memory instructions.
    always_comb begin
        if (control_in[CTL_BRANCH]) begin
            alu_wb_s = control_in[CTL_MEM_TO_REG] ? alu_output_in : next_pc_in;
        end else begin
            alu_wb_s = alu_output_in;
        end
    end

    load_align u_load_align (
        .rdata   (mem_rdata),
        .lane    (mem_addr[1:0]),
        .is_byte (is_byte_s),
        .value   (load_val_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    state_nx_s = trap_s ? RESP : REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack || (cnt_r == CNT_LAST)) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = REQ;
                end
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: hold EX/M while a memory op is launching or outstanding.
    always_comb begin
        case (state_r)
            IDLE:    stall = mem_op_s;
            REQ:     stall = 1'b1;
            RESP:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Data-memory request port; fields stay frozen while the request is open.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s && !trap_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_write_s;
                        mem_addr  <= addr_s;
                        mem_be    <= be_s;
                        mem_wdata <= store_data(data_in, is_byte_s);
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                REQ:     mem_req <= (state_nx_s == REQ);
                default: mem_req <= 1'b0;
            endcase
        end
    end

    // Timeout counter, abort pulse and load capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= 8'd0;
            mem_error <= 1'b0;
            load_r    <= 32'h0000_0000;
            failed_r  <= 1'b0;
        end else begin
            mem_error <= timeout_s;
            case (state_r)
                IDLE: begin
                    cnt_r    <= 8'd0;
                    failed_r <= trap_s;
                end
                REQ: begin
                    cnt_r    <= (state_nx_s == REQ) ? cnt_r + 8'd1 : 8'd0;
                    failed_r <= ~mem_ack;
                    if (mem_ack) begin
                        load_r <= load_val_s;
                    end else begin
                        load_r <= load_r;
                    end
                end
                default: cnt_r <= 8'd0;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Trap pulse lands in the RESP cycle of a misaligned word access.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= (state_r == IDLE) & trap_s;
        end
    end
`endif

    // M/WB register: bubbles while stalled, results on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data      <= 32'h0000_0000;
            wb_rgD       <= 5'd0;
            wb_reg_write <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_data      <= alu_wb_s;
                        wb_rgD       <= rgD_index_in;
                        wb_reg_write <= control_in[CTL_REG_WRITE];
                    end
                end
                RESP: begin
                    wb_data      <= is_write_s ? alu_output_in : load_r;
                    wb_rgD       <= rgD_index_in;
                    wb_reg_write <= control_in[CTL_REG_WRITE] & ~failed_r;
                end
                default: wb_reg_write <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random ops
// against a transaction-level reference model.
module tb_mem_stage_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_output_in, next_pc_in, data_in, mem_rdata;
    logic        take_branch_in, mem_ack;
    logic [5:0]  control_in;
    logic [4:0]  rgD_index_in;
    logic        stall, pc_redirect, mem_req, mem_we, mem_error, wb_reg_write;
    logic [31:0] pc_target, mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_be;
    logic [4:0]  wb_rgD;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .alu_output_in(alu_output_in), .next_pc_in(next_pc_in),
        .take_branch_in(take_branch_in), .data_in(data_in),
        .control_in(control_in), .rgD_index_in(rgD_index_in),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_error(mem_error), .wb_data(wb_data),
        .wb_rgD(wb_rgD), .wb_reg_write(wb_reg_write)
`ifdef MISALIGN_TRAP_EN
        , .misalign_trap(misalign_trap)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one EX/M instruction to completion. ack_at = REQ cycle index of the
    // ack (>= T means the memory never answers). Entered and left just after a negedge.
    task automatic run_op(input logic [5:0] ctl, input logic [31:0] alu, input logic [31:0] npc,
                          input logic br, input logic [31:0] din, input logic [4:0] rgd,
                          input int ack_at, input logic [31:0] rdata);
        logic        memop, is_byte, is_write, timed_out, exp_we_reg;
        logic [31:0] exp_addr, exp_wdata, exp_wb, load_val;
        logic [3:0]  exp_be;
        logic [7:0]  b;
        control_in = ctl; alu_output_in = alu; next_pc_in = npc; take_branch_in = br;
        data_in = din; rgD_index_in = rgd; mem_ack = 1'b0; mem_rdata = $urandom;
        memop    = ctl[0] | ctl[1];
        is_byte  = ctl[2];
        is_write = ctl[1];
        #1;
        chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, ctl[5] & br});
        chk("pc_target", pc_target, alu);
        if (!memop) begin
            chk("stall_alu", {31'd0, stall}, 32'd0);
            @(negedge clk); #1;
            exp_wb = ctl[5] ? (ctl[4] ? alu : npc) : alu;
            chk("wb_we_alu", {31'd0, wb_reg_write}, {31'd0, ctl[3]});
            chk("wb_data_alu", wb_data, exp_wb);
            chk("wb_rgD_alu", {27'd0, wb_rgD}, {27'd0, rgd});
            chk("mem_req_alu", {31'd0, mem_req}, 32'd0);
        end else begin
            chk("stall_idle", {31'd0, stall}, 32'd1);
            exp_be    = is_byte ? (4'b0001 << alu[1:0]) : 4'hF;
            exp_addr  = is_byte ? alu : (alu & ~32'h3);
            exp_wdata = is_byte ? ({24'd0, din[7:0]} * 32'h0101_0101) : din;
            b         = 8'((rdata >> (8 * alu[1:0])) & 32'hFF);
            load_val  = is_byte ? ((b >= 8'd128) ? ({24'd0, b} + 32'hFFFF_FF00) : {24'd0, b}) : rdata;
            timed_out = (ack_at >= T);
            @(negedge clk);
            for (int k = 0; k < T; k++) begin
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rdata : $urandom;
                #1;
                chk("mem_req_req", {31'd0, mem_req}, 32'd1);
                chk("stall_req", {31'd0, stall}, 32'd1);
                if (k == 0) begin
                    chk("mem_we", {31'd0, mem_we}, {31'd0, is_write});
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                    if (is_write) chk("mem_wdata", mem_wdata, exp_wdata);
                    chk("wb_bubble", {31'd0, wb_reg_write}, 32'd0);
                end
                @(negedge clk);
                if ((k == ack_at) || (k == T - 1)) break;
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
            #1;
            chk("mem_req_resp", {31'd0, mem_req}, 32'd0);
            chk("stall_resp", {31'd0, stall}, 32'd0);
            chk("mem_error_resp", {31'd0, mem_error}, {31'd0, timed_out});
`ifdef MISALIGN_TRAP_EN
            chk("misalign_trap", {31'd0, misalign_trap}, 32'd0);
`endif
            @(negedge clk); #1;
            exp_we_reg = ctl[3] & ~timed_out;
            chk("wb_we_mem", {31'd0, wb_reg_write}, {31'd0, exp_we_reg});
            if (exp_we_reg) begin
                chk("wb_data_mem", wb_data, is_write ? alu : load_val);
                chk("wb_rgD_mem", {27'd0, wb_rgD}, {27'd0, rgd});
            end
            chk("mem_error_after", {31'd0, mem_error}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  ctl;
        logic [31:0] alu;
        int          kind, ack_at;

        reset = 1'b1; control_in = 6'd0; alu_output_in = 32'd0; next_pc_in = 32'd0;
        take_branch_in = 1'b0; data_in = 32'd0; rgD_index_in = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_error", {31'd0, mem_error}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rgD", {27'd0, wb_rgD}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_reg_write}, 32'd0);
        reset = 1'b0;

        // ALU op, word load with late ack, byte store, byte load, timeout.
        run_op(6'b001000, 32'h0000_1234, 32'h0000_0040, 1'b0, 32'd0, 5'd7, 0, 32'd0);
        run_op(6'b011001, 32'h0000_0100, 32'h0, 1'b0, 32'd0, 5'd3, 2, 32'hDEAD_BEEF);
        run_op(6'b000110, 32'h0000_0203, 32'h0, 1'b0, 32'h0000_00AB, 5'd4, 0, 32'd0);
        run_op(6'b011101, 32'h0000_0101, 32'h0, 1'b0, 32'd0, 5'd9, 1, 32'h0000_8000);
        run_op(6'b011001, 32'h0000_0200, 32'h0, 1'b0, 32'd0, 5'd5, T, 32'd0);
        run_op(6'b101000, 32'h0000_0300, 32'h0000_0404, 1'b1, 32'd0, 5'd1, 0, 32'd0);

        // Reset during REQ followed by a stray ack.
        control_in = 6'b011001; alu_output_in = 32'h0000_0500; rgD_index_in = 5'd6;
        @(negedge clk); #1;
        chk("rstreq_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; control_in = 6'd0;
        @(negedge clk);
        reset = 1'b0; #1;
        chk("rstreq_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstreq_stall", {31'd0, stall}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0; #1;
        chk("stray_wb_we", {31'd0, wb_reg_write}, 32'd0);
        chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        chk("stray_mem_error", {31'd0, mem_error}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            ctl  = 6'($urandom);
            alu  = $urandom;
            ack_at = 0;
            if (kind == 0) begin
                ctl[1:0] = 2'b00;
            end else if (kind == 1) begin
                ctl[1:0] = 2'b01;
                ack_at = $urandom_range(0, T);
            end else begin
                ctl[1] = 1'b1;
                ctl[0] = 1'($urandom_range(0, 1));
                ack_at = $urandom_range(0, T - 1);
            end
`ifdef MISALIGN_TRAP_EN
            if (kind != 0 && !ctl[2]) alu[1:0] = 2'b00;
`endif
            run_op(ctl, alu, $urandom, 1'($urandom_range(0, 1)), $urandom,
                   5'($urandom_range(0, 31)), ack_at, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage consumer of the EX/M pipeline register.
- Decodes the registered EX/M bundle (ALU result, next PC, branch flag, store data, 6-bit control, rgD index) and runs load/store transactions on a valid/ack data-memory port.
- Drives the stall that freezes EX/M and earlier stages, and owns the M/WB register feeding writeback.
- Also emits the branch redirect resolved from EX/M.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without mem_ack before abort; range 1..255.
- ADDR_W, 32: data-memory address width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- alu_output_in  input  32  EX/M ALU result; memory address or writeback value
- next_pc_in  input  32  EX/M PC+4; writeback value for link ops
- take_branch_in  input  1  EX/M ALU branch condition
- data_in  input  32  EX/M store data
- control_in  input  6  EX/M control: [0] mem_read, [1] mem_write, [2] byte, [3] reg_write, [4] mem_to_reg, [5] branch
- rgD_index_in  input  5  EX/M destination register
- stall  output  1  high = hold EX/M and upstream (EX/M write = ~stall)
- pc_redirect  output  1  control_in[5] & take_branch_in, combinational
- pc_target  output  32  alu_output_in, combinational
- mem_req  output  1  registered request valid
- mem_we  output  1  registered write enable
- mem_addr  output  ADDR_W  registered address; word-aligned for word ops
- mem_be  output  4  registered byte enables
- mem_wdata  output  32  registered store data; byte replicated to all lanes for byte stores
- mem_ack  input  1  memory completion, 1-cycle pulse
- mem_rdata  input  32  load data, valid with mem_ack
- mem_error  output  1  1-cycle pulse on timeout abort
- wb_data  output  32  M/WB writeback value
- wb_rgD  output  5  M/WB destination
- wb_reg_write  output  1  M/WB write enable

Behaviour:
- Reset: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_error, wb_* all 0; timeout counter 0. Pending transaction abandoned; mem_ack arriving after reset is ignored in IDLE.
- mem_op = control_in[0] | control_in[1]; both set is treated as a write.
- IDLE, no mem_op: stall=0. M/WB loads at next edge: wb_data = control_in[4] ? alu_output_in : next_pc_in when control_in[5], else alu_output_in; wb_reg_write = control_in[3]. Latency 1 cycle.
- IDLE, mem_op: stall=1 combinationally. Register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata. Go REQ. M/WB loads a bubble (wb_reg_write=0).
- Address and byte enables: byte op, mem_be = 1 << addr[1:0], mem_addr = full address. Word op, mem_be = 4'hF, mem_addr = {addr[31:2], 2'b00}.
- REQ: stall=1; mem_req and request fields held stable; counter increments each cycle.
  - mem_ack=1: capture load data (byte lane selected by addr[1:0], sign-extended), drop mem_req, go RESP. mem_ack is valid no earlier than the first REQ cycle.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: drop mem_req, pulse mem_error, go RESP with the load marked failed.
- RESP: stall=0, so EX/M advances at this edge. M/WB loads: wb_data = load data for reads, alu_output_in for writes; wb_reg_write = control_in[3] & ~failed. Counter cleared. Go IDLE.
- Minimum mem-op occupancy: 3 cycles (IDLE, REQ with immediate ack, RESP); stall high for 2 of them.
- mem_ack in IDLE or RESP is ignored.
- pc_redirect is combinational from EX/M in every state; fetch gates it with ~stall.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: word op with addr[1:0] != 0 issues no request. IDLE goes directly to RESP with stall=1 for that one IDLE cycle. Output misalign_trap (1 bit, registered pulse in RESP) is asserted; wb_reg_write is forced 0.
- Undefined: low address bits are silently dropped (word-aligned access), and the misalign_trap port does not exist.

Decomposition:
- Package mem_stage_pkg: control bit index constants (CTL_MEM_READ=0 .. CTL_BRANCH=5), state enum {IDLE, REQ, RESP}, BE_WORD=4'hF.
- Sub-module load_align: combinational lane select plus sign extension (mem_rdata, addr[1:0], byte) -> 32-bit load value.

Test Plan:
- ALU op (control 6'b001000, alu_output_in 0x1234, rgD 7) -> stall stays 0; next cycle wb_data=0x1234, wb_rgD=7, wb_reg_write=1.
- Word load at addr 0x100, ack on 3rd REQ cycle with rdata 0xDEADBEEF -> mem_req high 3 cycles, mem_be=F; stall high 4 cycles; wb_data=0xDEADBEEF.
- Byte store to 0x203, data_in 0x000000AB -> mem_we=1, mem_be=4'b1000, mem_wdata=0xABABABAB; wb_reg_write=0.
- Byte load at 0x101, rdata 0x0000_80_00 -> wb_data=0xFFFFFF80.
- No ack, TIMEOUT_CYCLES=4 -> mem_req drops after 4 REQ cycles; mem_error pulses once; wb_reg_write=0; stall released in RESP.
- Reset asserted during REQ, ack one cycle later -> mem_req=0 and state IDLE after the reset edge; stray ack produces no M/WB write.
